// File: rtl/scalar_rf_arbiter_pkg.sv
// Shared types and widths for the scalar register-file arbiter slice.
package srf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int WR_REQ_NUM          = 2;
  localparam int BIT_NUMBER_DEF      = 32;
  localparam int ADDR_NUMBER_DEF     = 5;
  localparam int REGISTER_NUMBER_DEF = 16;

  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
    return addr < limit;
  endfunction

endpackage

// File: rtl/scalar_rf_arbiter_if.sv
// Requester-side handshake bundle: two write requesters plus one dual-operand read port.
interface scalar_rf_arbiter_if
  import srf_pkg::*;
#(
  parameter int BIT_NUMBER  = BIT_NUMBER_DEF,
  parameter int ADDR_NUMBER = ADDR_NUMBER_DEF
);
  logic [WR_REQ_NUM-1:0]             wr_valid;
  logic [WR_REQ_NUM-1:0]             wr_ready;
  logic [WR_REQ_NUM*ADDR_NUMBER-1:0] wr_addr;
  logic [WR_REQ_NUM*BIT_NUMBER-1:0]  wr_data;
  logic                              rd_valid;
  logic                              rd_ready;
  logic [ADDR_NUMBER-1:0]            rd_addr_1;
  logic [ADDR_NUMBER-1:0]            rd_addr_2;
  logic                              rd_resp_valid;
  logic                              rd_resp_err;
  logic [BIT_NUMBER-1:0]             rd_resp_data_1;
  logic [BIT_NUMBER-1:0]             rd_resp_data_2;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr_1, rd_addr_2,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_err, rd_resp_data_1, rd_resp_data_2
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr_1, rd_addr_2,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_err, rd_resp_data_1, rd_resp_data_2
  );
endinterface

// File: rtl/scalar_rf_arbiter_rr.sv
// Two-way round-robin grant; pointer moves to the loser after each taken grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);
  logic ptr;

  always_comb begin
    grant_idx = req[ptr] ? ptr : ~ptr;
    grant     = (|req) ? (2'b01 << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= ~grant_idx;
  end
endmodule

// File: rtl/scalar_rf_arbiter.sv
// Arbitrates ALU/load writeback and operand reads onto a single-ported register file.
module scalar_rf_arbiter
  import srf_pkg::*;
#(
  parameter int BIT_NUMBER      = BIT_NUMBER_DEF,
  parameter int ADDR_NUMBER     = ADDR_NUMBER_DEF,
  parameter int REGISTER_NUMBER = REGISTER_NUMBER_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  scalar_rf_arbiter_if.slave      bus,
  output logic                    rf_enable,
  output logic                    rf_write_enable,
  output logic [ADDR_NUMBER-1:0]  rf_dest_addr,
  output logic [BIT_NUMBER-1:0]   rf_write_data,
  output logic [ADDR_NUMBER-1:0]  rf_src_addr_1,
  output logic [ADDR_NUMBER-1:0]  rf_src_addr_2,
  input  logic [2*BIT_NUMBER-1:0] rf_data_in
);
  state_t state, next_state;
  logic   prio_write;
  logic   pick_write, pick_read, resp_active;
  logic   rd_err_q, rd_err_d;
  logic   wr_ok, rd_ok, wr_idx;
  logic [WR_REQ_NUM-1:0]  wr_gnt;
  logic [ADDR_NUMBER-1:0] wr_sel_addr;
  logic [BIT_NUMBER-1:0]  wr_sel_data;
  logic                   rf_en_q, rf_en_d, rf_we_q, rf_we_d;
  logic [ADDR_NUMBER-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [BIT_NUMBER-1:0]  wdata_q, wdata_d;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.wr_valid),
    .advance   (pick_write),
    .grant     (wr_gnt),
    .grant_idx (wr_idx)
  );

  assign wr_sel_addr = wr_idx ? bus.wr_addr[2*ADDR_NUMBER-1:ADDR_NUMBER] : bus.wr_addr[ADDR_NUMBER-1:0];
  assign wr_sel_data = wr_idx ? bus.wr_data[2*BIT_NUMBER-1:BIT_NUMBER]   : bus.wr_data[BIT_NUMBER-1:0];
  assign wr_ok = addr_ok(32'(wr_sel_addr), 32'(REGISTER_NUMBER));
  assign rd_ok = addr_ok(32'(bus.rd_addr_1), 32'(REGISTER_NUMBER)) &&
                 addr_ok(32'(bus.rd_addr_2), 32'(REGISTER_NUMBER));

  // Class choice only matters when both classes pend; prio_write breaks the tie.
  always_comb begin
    pick_write = 1'b0;
    pick_read  = 1'b0;
    if (state == IDLE && !reset) begin
      if ((|bus.wr_valid) && (!bus.rd_valid || prio_write)) pick_write = 1'b1;
      else if (bus.rd_valid)                                 pick_read  = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pick_write) next_state = WRITE;
               else if (pick_read) next_state = READ;
      WRITE:   next_state = IDLE;
      READ:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (reset) next_state = IDLE;
  end

  always_comb begin
    resp_active        = (state == RESP) && !reset;
    bus.wr_ready       = pick_write ? wr_gnt : '0;
    bus.rd_ready       = pick_read;
    bus.rd_resp_valid  = resp_active;
    bus.rd_resp_err    = resp_active && rd_err_q;
    bus.rd_resp_data_1 = '0;
    bus.rd_resp_data_2 = '0;
    if (resp_active && !rd_err_q) begin
      bus.rd_resp_data_1 = rf_data_in[BIT_NUMBER-1:0];
      bus.rd_resp_data_2 = rf_data_in[2*BIT_NUMBER-1:BIT_NUMBER];
    end
    // Next values of the registered RF-side outputs, taken from the request granted now.
    rf_en_d  = 1'b0;
    rf_we_d  = 1'b0;
    dest_d   = '0;
    wdata_d  = '0;
    src1_d   = '0;
    src2_d   = '0;
    rd_err_d = rd_err_q;
    if (pick_write) begin
      rf_en_d = wr_ok;
      rf_we_d = wr_ok;
      if (wr_ok) begin
        dest_d  = wr_sel_addr;
        wdata_d = wr_sel_data;
      end
    end else if (pick_read) begin
      rd_err_d = !rd_ok;
      rf_en_d  = rd_ok;
      if (rd_ok) begin
        src1_d = bus.rd_addr_1;
        src2_d = bus.rd_addr_2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prio_write <= 1'b1;
      rd_err_q   <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      dest_q     <= '0;
      wdata_q    <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
    end else begin
      state      <= next_state;
      if (pick_write)     prio_write <= 1'b0;
      else if (pick_read) prio_write <= 1'b1;
      rd_err_q   <= rd_err_d;
      rf_en_q    <= rf_en_d;
      rf_we_q    <= rf_we_d;
      dest_q     <= dest_d;
      wdata_q    <= wdata_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
    end
  end

  // Masking with reset keeps the RF quiet during the reset cycle itself.
  assign rf_enable       = rf_en_q && !reset;
  assign rf_write_enable = rf_we_q && !reset;
  assign rf_dest_addr    = reset ? '0 : dest_q;
  assign rf_write_data   = reset ? '0 : wdata_q;
  assign rf_src_addr_1   = reset ? '0 : src1_q;
  assign rf_src_addr_2   = reset ? '0 : src2_q;
endmodule

// File: doc/scalar_rf_arbiter.md
SCALAR_RF_ARBITER -- requirements
Module: scalar_rf_arbiter

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 32, data width.
REQ-002 SHALL have parameter ADDR_NUMBER, default 5, register address width.
REQ-003 SHALL have parameter REGISTER_NUMBER, default 16, implemented registers.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_valid  input  2  write request per requester (bit 0 = ALU writeback, bit 1 = load unit).
REQ-007 SHALL have port wr_ready  output  2  write accepted this cycle, per requester.
REQ-008 SHALL have port wr_addr  input  2*ADDR_NUMBER  destination address per requester, requester 0 in low bits.
REQ-009 SHALL have port wr_data  input  2*BIT_NUMBER  write data per requester, requester 0 in low bits.
REQ-010 SHALL have port rd_valid  input  1  read request for two source operands.
REQ-011 SHALL have port rd_ready  output  1  read request accepted this cycle.
REQ-012 SHALL have port rd_addr_1  input  ADDR_NUMBER  first source address.
REQ-013 SHALL have port rd_addr_2  input  ADDR_NUMBER  second source address.
REQ-014 SHALL have port rd_resp_valid  output  1  one-cycle pulse, read data valid.
REQ-015 SHALL have port rd_resp_data_1  output  BIT_NUMBER  first operand.
REQ-016 SHALL have port rd_resp_data_2  output  BIT_NUMBER  second operand.
REQ-017 SHALL have port rd_resp_err  output  1  with rd_resp_valid: an address >= REGISTER_NUMBER; data forced to 0.
REQ-018 SHALL have port rf_enable  output  1  register file enable.
REQ-019 SHALL have port rf_write_enable  output  1  register file write enable.
REQ-020 SHALL have port rf_dest_addr  output  ADDR_NUMBER  register file write address.
REQ-021 SHALL have port rf_write_data  output  BIT_NUMBER  register file write data.
REQ-022 SHALL have port rf_src_addr_1  output  ADDR_NUMBER  register file read address 1.
REQ-023 SHALL have port rf_src_addr_2  output  ADDR_NUMBER  register file read address 2.
REQ-024 SHALL have port rf_data_in  input  2*BIT_NUMBER  register file outputs {data_out_2, data_out_1}.

Function
REQ-025 SHALL implement FSM states IDLE, WRITE, READ, RESP; rf_* outputs registered, driven only from state.
REQ-026 SHALL, in IDLE with any request pending, choose write or read and latch the chosen request's addr/data; wr_ready/rd_ready asserted combinationally in that same cycle for the chosen requester only.
REQ-027 SHALL arbitrate the two write requesters round-robin; rr pointer toggles to the non-granted requester after each write grant.
REQ-028 SHALL, when writes and reads both pend, alternate class priority (write, read, write...); flag flips after each grant; after reset writes win first.
REQ-029 SHALL in WRITE assert rf_enable=1, rf_write_enable=1 for exactly one cycle, then return to IDLE; no read-hazard forwarding is performed.
REQ-030 SHALL drop a write with address >= REGISTER_NUMBER (handshake completes, rf_enable stays 0).
REQ-031 SHALL in READ assert rf_enable=1, rf_write_enable=0 for one cycle; RESP next cycle samples rf_data_in and pulses rd_resp_valid; read latency accept-to-response is 2 cycles.
REQ-032 SHALL for an out-of-range read skip the RF access (READ with rf_enable=0) and respond rd_resp_err=1, data 0, same latency.
REQ-033 SHALL never assert wr_ready and rd_ready together; throughput max one access per 2 cycles (writes) / 3 cycles (reads).

Reset
REQ-034 SHALL on reset, including mid-operation, go to IDLE, discard latched request, drive all outputs 0, rr pointer to requester 0, class priority to write.
REQ-035 SHALL not issue any RF access in the cycle reset is high; an in-flight read produces no response.

Structure
REQ-036 SHALL place FSM state encoding and port-width localparams in shared package srf_pkg.
REQ-037 SHALL use one sub-module rr_arbiter2 (2-way round-robin grant with pointer); remainder flat.

Verification
REQ-038 Write req0 addr 3 data 0xA5A5A5A5 -> wr_ready[0] 1 cycle, next cycle rf_write_enable=1, rf_dest_addr=3.
REQ-039 wr_valid=2'b11 held 4 grants -> grant order 0,1,0,1.
REQ-040 Read 3,7 with rf_data_in={0x7,0xA5A5A5A5} -> rd_resp_valid 2 cycles after rd_ready, data_1=0xA5A5A5A5, data_2=0x7.
REQ-041 rd_valid and wr_valid[1] constantly high -> grants alternate write, read, write; never simultaneous ready.
REQ-042 Read addr_2=20 -> rf_enable stays 0, rd_resp_err=1, data 0; reset asserted in READ -> no rd_resp_valid, outputs 0.
